// File: rtl/m3_dequant_writer_pkg.sv
// Shared types and tables for the milestone-3 dequantizer / pre-IDCT SRAM writer.
// Zigzag entries are packed {r[2:0], c[2:0]}, i.e. the raster position inside the 8x8 block.
package m3_dequant_writer_pkg;

    typedef enum logic [1:0] {
        S_IDLE_M3  = 2'd0,
        S_RUN_M3   = 2'd1,
        S_FLUSH_M3 = 2'd2,
        S_DONE_M3  = 2'd3
    } m3_state_type;

    localparam logic [17:0] PRE_IDCT_BASE = 18'd76800;
    localparam logic [17:0] U_BASE        = 18'd153600;
    localparam logic [17:0] V_BASE        = 18'd192000;

    localparam int Y_WIDTH     = 320;
    localparam int UV_WIDTH    = 160;
    localparam int Y_BLK_COLS  = Y_WIDTH / 8;
    localparam int UV_BLK_COLS = UV_WIDTH / 8;
    localparam int BLK_ROWS    = 30;

    localparam logic [5:0] ZZ [0:63] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // Shift amounts indexed by s = r + c (0..14).
    function automatic logic [2:0] q0_shift(input logic [3:0] s);
        case (s)
            4'd0:    q0_shift = 3'd3;
            4'd1:    q0_shift = 3'd2;
            4'd2:    q0_shift = 3'd3;
            4'd3:    q0_shift = 3'd4;
            4'd4:    q0_shift = 3'd4;
            4'd5:    q0_shift = 3'd5;
            default: q0_shift = 3'd6;
        endcase
    endfunction

    function automatic logic [2:0] q1_shift(input logic [3:0] s);
        case (s)
            4'd0:    q1_shift = 3'd3;
            4'd1:    q1_shift = 3'd1;
            4'd2:    q1_shift = 3'd1;
            4'd3:    q1_shift = 3'd1;
            4'd4:    q1_shift = 3'd2;
            4'd5:    q1_shift = 3'd2;
            4'd6:    q1_shift = 3'd3;
            4'd7:    q1_shift = 3'd3;
            default: q1_shift = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/m3_zigzag_addr_gen.sv
// Maps (plane, block row/col, zigzag index) to the raster SRAM word address and
// picks the dequantization shift for that coefficient position.
module m3_zigzag_addr_gen
    import m3_dequant_writer_pkg::*;
(
    input  logic [5:0]  coef_idx,
    input  logic [4:0]  blk_row,
    input  logic [5:0]  blk_col,
    input  logic [1:0]  plane,
    input  logic        q_sel,
    output logic [17:0] address,
    output logic [2:0]  shift
);

    logic [5:0]  zz_pos;
    logic [2:0]  r;
    logic [2:0]  c;
    logic [3:0]  s;
    logic [7:0]  row;
    logic [8:0]  col;
    logic [17:0] row_wide;
    logic [17:0] row_off;
    logic [17:0] plane_base;

    assign zz_pos   = ZZ[coef_idx];
    assign r        = zz_pos[5:3];
    assign c        = zz_pos[2:0];
    assign s        = {1'b0, r} + {1'b0, c};
    assign row      = {blk_row, r};
    assign col      = {blk_col, c};
    assign row_wide = {10'd0, row};

    // 320 = 256 + 64 and 160 = 128 + 32, so each row offset is two shifted copies.
    always_comb begin
        row_off    = (row_wide << 8) + (row_wide << 6);
        plane_base = PRE_IDCT_BASE;
        if (plane != 2'd0) begin
            row_off    = (row_wide << 7) + (row_wide << 5);
            plane_base = (plane == 2'd1) ? U_BASE : V_BASE;
        end
    end

    assign address = plane_base + row_off + {9'd0, col};
    assign shift   = q_sel ? q1_shift(s) : q0_shift(s);

endmodule

// File: rtl/m3_dequant_writer.sv
// Accepts zigzag-ordered quantized coefficients, dequantizes by a power-of-two shift
// with signed-16 saturation, and writes them in raster order to the pre-IDCT SRAM area.
module m3_dequant_writer
    import m3_dequant_writer_pkg::*;
(
    input  logic        CLOCK_50_I,
    input  logic        resetn,
    input  logic        m3_start,
    input  logic        q_sel,
    input  logic        coef_valid,
    input  logic [15:0] coef_data,
    output logic        coef_ready,
    output logic [17:0] M3_SRAM_address,
    output logic [15:0] M3_SRAM_write_data,
    output logic        M3_SRAM_we_n,
    output logic        block_done,
    output logic        m3_finish
);

    m3_state_type state_q, state_d;
    logic         q_sel_q, q_sel_d;
    logic [5:0]   coef_idx_q, coef_idx_d;
    logic [5:0]   blk_col_q, blk_col_d;
    logic [4:0]   blk_row_q, blk_row_d;
    logic [1:0]   plane_q, plane_d;
    logic [17:0]  addr_q, addr_d;
    logic [15:0]  data_q, data_d;
    logic         we_n_q, we_n_d;
    logic         block_done_q, block_done_d;

    logic         accept;
    logic         last_coef;
    logic         last_col;
    logic         last_row;
    logic         final_coef;
    logic [17:0]  gen_address;
    logic [2:0]   gen_shift;
    logic [22:0]  wide;
    logic [15:0]  sat_data;

    m3_zigzag_addr_gen u_addr_gen (
        .coef_idx (coef_idx_q),
        .blk_row  (blk_row_q),
        .blk_col  (blk_col_q),
        .plane    (plane_q),
        .q_sel    (q_sel_q),
        .address  (gen_address),
        .shift    (gen_shift)
    );

    assign coef_ready = (state_q == S_RUN_M3);
    assign m3_finish  = (state_q == S_DONE_M3);
    assign accept     = coef_valid && coef_ready;

    assign last_coef  = (coef_idx_q == 6'd63);
    assign last_col   = (plane_q == 2'd0) ? (blk_col_q == 6'(Y_BLK_COLS - 1))
                                          : (blk_col_q == 6'(UV_BLK_COLS - 1));
    assign last_row   = (blk_row_q == 5'(BLK_ROWS - 1));
    assign final_coef = last_coef && last_col && last_row && (plane_q == 2'd2);

    // Shift of at most 6 fits in 23 bits; any disagreement in the top 8 bits means overflow.
    assign wide = $signed({{7{coef_data[15]}}, coef_data}) <<< gen_shift;

    always_comb begin
        sat_data = wide[15:0];
        if (wide[22:15] != {8{wide[22]}}) begin
            sat_data = wide[22] ? 16'h8000 : 16'h7FFF;
        end
    end

    always_comb begin
        state_d    = state_q;
        q_sel_d    = q_sel_q;
        coef_idx_d = coef_idx_q;
        blk_col_d  = blk_col_q;
        blk_row_d  = blk_row_q;
        plane_d    = plane_q;
        case (state_q)
            S_IDLE_M3: begin
                if (m3_start) begin
                    state_d    = S_RUN_M3;
                    q_sel_d    = q_sel;
                    coef_idx_d = 6'd0;
                    blk_col_d  = 6'd0;
                    blk_row_d  = 5'd0;
                    plane_d    = 2'd0;
                end
            end
            S_RUN_M3: begin
                if (accept) begin
                    coef_idx_d = coef_idx_q + 6'd1;
                    if (last_coef) begin
                        blk_col_d = blk_col_q + 6'd1;
                        if (last_col) begin
                            blk_col_d = 6'd0;
                            blk_row_d = blk_row_q + 5'd1;
                            if (last_row) begin
                                blk_row_d = 5'd0;
                                plane_d   = plane_q + 2'd1;
                            end
                        end
                    end
                    if (final_coef) begin
                        plane_d = 2'd0;
                        state_d = S_FLUSH_M3;
                    end
                end
            end
            S_FLUSH_M3: state_d = S_DONE_M3;
            S_DONE_M3:  state_d = S_IDLE_M3;
            default:    state_d = S_IDLE_M3;
        endcase
    end

    always_comb begin
        we_n_d       = ~accept;
        block_done_d = accept && last_coef;
        addr_d       = accept ? gen_address : addr_q;
        data_d       = accept ? sat_data : data_q;
    end

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE_M3;
            q_sel_q      <= 1'b0;
            coef_idx_q   <= 6'd0;
            blk_col_q    <= 6'd0;
            blk_row_q    <= 5'd0;
            plane_q      <= 2'd0;
            addr_q       <= 18'd0;
            data_q       <= 16'd0;
            we_n_q       <= 1'b1;
            block_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            q_sel_q      <= q_sel_d;
            coef_idx_q   <= coef_idx_d;
            blk_col_q    <= blk_col_d;
            blk_row_q    <= blk_row_d;
            plane_q      <= plane_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            we_n_q       <= we_n_d;
            block_done_q <= block_done_d;
        end
    end

    assign M3_SRAM_address    = addr_q;
    assign M3_SRAM_write_data = data_q;
    assign M3_SRAM_we_n       = we_n_q;
    assign block_done         = block_done_q;

endmodule

// File: tb/tb_m3_dequant_writer.sv
// Self-checking bench for m3_dequant_writer against an arithmetic model of the
// plane/block raster layout, a generated zigzag walk and the dequant shift tables.
module tb_m3_dequant_writer;

    logic        clk;
    logic        resetn;
    logic        m3_start;
    logic        q_sel;
    logic        coef_valid;
    logic [15:0] coef_data;
    logic        coef_ready;
    logic [17:0] M3_SRAM_address;
    logic [15:0] M3_SRAM_write_data;
    logic        M3_SRAM_we_n;
    logic        block_done;
    logic        m3_finish;

    int compared   = 0;
    int mismatched = 0;

    int seq;
    bit qsel_m;
    int zz_r [0:63];
    int zz_c [0:63];
    int q0_tab [0:6] = '{3, 2, 3, 4, 4, 5, 6};
    int q1_tab [0:8] = '{3, 1, 1, 1, 2, 2, 3, 3, 4};

    m3_dequant_writer dut (
        .CLOCK_50_I         (clk),
        .resetn             (resetn),
        .m3_start           (m3_start),
        .q_sel              (q_sel),
        .coef_valid         (coef_valid),
        .coef_data          (coef_data),
        .coef_ready         (coef_ready),
        .M3_SRAM_address    (M3_SRAM_address),
        .M3_SRAM_write_data (M3_SRAM_write_data),
        .M3_SRAM_we_n       (M3_SRAM_we_n),
        .block_done         (block_done),
        .m3_finish          (m3_finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

    // Zigzag walk: anti-diagonal s = r + c, odd diagonals go down-left, even ones up-right.
    task automatic build_zigzag();
        int k = 0;
        for (int s = 0; s <= 14; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 1) begin
                for (int r = lo; r <= hi; r++) begin zz_r[k] = r; zz_c[k] = s - r; k++; end
            end else begin
                for (int r = hi; r >= lo; r--) begin zz_r[k] = r; zz_c[k] = s - r; k++; end
            end
        end
    endtask

    // n = global coefficient number since start (block = n/64, zigzag index = n%64).
    function automatic int exp_addr(int n);
        int blk = n / 64;
        int idx = n % 64;
        int base, w, b;
        if (blk < 1200)      begin base = 76800;  w = 320; b = blk;        end
        else if (blk < 1800) begin base = 153600; w = 160; b = blk - 1200; end
        else                 begin base = 192000; w = 160; b = blk - 1800; end
        return base + ((b / (w / 8)) * 8 + zz_r[idx]) * w + (b % (w / 8)) * 8 + zz_c[idx];
    endfunction

    function automatic logic [15:0] exp_data(logic [15:0] cd, int idx, bit qs);
        int s = zz_r[idx] + zz_c[idx];
        int sh = qs ? q1_tab[(s > 8) ? 8 : s] : q0_tab[(s > 6) ? 6 : s];
        int v = int'($signed(cd)) * (1 << sh);
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return 16'(v);
    endfunction

    task automatic restart(bit qs);
        @(negedge clk);
        resetn = 1'b0; coef_valid = 1'b0; m3_start = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        m3_start = 1'b1; q_sel = qs;
        @(negedge clk);
        m3_start = 1'b0; q_sel = ~qs;
        seq = 0; qsel_m = qs;
    endtask

    // Drive one cycle of stimulus; returns just after the capturing edge with valid dropped.
    task automatic send(bit v, logic [15:0] cd);
        @(negedge clk);
        coef_valid = v; coef_data = cd;
        @(posedge clk);
        #1;
        coef_valid = 1'b0;
        $display("txn t=%0t valid=%b coef=%h -> we_n=%b addr=%0d data=%h done=%b ready=%b",
                 $time, v, cd, M3_SRAM_we_n, M3_SRAM_address, M3_SRAM_write_data, block_done, coef_ready);
    endtask

    // Place the counters at an arbitrary coefficient so distant plane boundaries are reachable.
    task automatic jump(int blk, int idx);
        int base_blk, cols, b;
        int plane;
        if (blk < 1200)      begin plane = 0; base_blk = 0;    cols = 40; end
        else if (blk < 1800) begin plane = 1; base_blk = 1200; cols = 20; end
        else                 begin plane = 2; base_blk = 1800; cols = 20; end
        b = blk - base_blk;
        @(negedge clk);
        force dut.coef_idx_q = 6'(idx);
        force dut.blk_col_q  = 6'(b % cols);
        force dut.blk_row_q  = 5'(b / cols);
        force dut.plane_q    = 2'(plane);
        #1;
        release dut.coef_idx_q;
        release dut.blk_col_q;
        release dut.blk_row_q;
        release dut.plane_q;
        seq = blk * 64 + idx;
    endtask

    task automatic test_reset();
        resetn = 1'b0; m3_start = 1'b0; q_sel = 1'b0; coef_valid = 1'b0; coef_data = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        if (coef_ready !== 1'b0) begin mismatched++; $display("FAIL reset_ready: got %b required 0", coef_ready); end
        compared++;
        if (M3_SRAM_we_n !== 1'b1) begin mismatched++; $display("FAIL reset_we_n: got %b required 1", M3_SRAM_we_n); end
        compared++;
        if (M3_SRAM_address !== 18'd0) begin mismatched++; $display("FAIL reset_addr: got %0d required 0", M3_SRAM_address); end
        compared++;
        if (M3_SRAM_write_data !== 16'd0) begin mismatched++; $display("FAIL reset_data: got %h required 0000", M3_SRAM_write_data); end
        compared++;
        if (block_done !== 1'b0 || m3_finish !== 1'b0) begin
            mismatched++; $display("FAIL reset_pulses: got done=%b finish=%b required 0/0", block_done, m3_finish);
        end
        compared++;
        resetn = 1'b1;
    endtask

    task automatic test_first_coefs();
        int want_a [0:2] = '{76800, 76801, 77120};
        logic [15:0] want_d [0:2] = '{16'd40, 16'd20, 16'd20};
        restart(1'b0);
        if (coef_ready !== 1'b1) begin mismatched++; $display("FAIL start_ready: got %b required 1", coef_ready); end
        compared++;
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 16'd5);
            if (M3_SRAM_we_n !== 1'b0 || M3_SRAM_address !== 18'(want_a[i]) || M3_SRAM_write_data !== want_d[i]) begin
                mismatched++;
                $display("FAIL first_coef%0d: got we_n=%b addr=%0d data=%0d required we_n=0 addr=%0d data=%0d",
                         i, M3_SRAM_we_n, M3_SRAM_address, M3_SRAM_write_data, want_a[i], want_d[i]);
            end
            compared++;
            seq++;
        end
    endtask

    task automatic test_full_block();
        restart(1'b1);
        for (int i = 0; i < 65; i++) begin
            int ea = exp_addr(seq);
            logic [15:0] ed = exp_data(16'd1, seq % 64, qsel_m);
            bit edone = (seq % 64 == 63);
            send(1'b1, 16'd1);
            if (M3_SRAM_we_n !== 1'b0 || M3_SRAM_address !== 18'(ea) || M3_SRAM_write_data !== ed || block_done !== edone) begin
                mismatched++;
                $display("FAIL full_block idx%0d: got we_n=%b addr=%0d data=%0d done=%b required we_n=0 addr=%0d data=%0d done=%b",
                         i, M3_SRAM_we_n, M3_SRAM_address, M3_SRAM_write_data, block_done, ea, ed, edone);
            end
            compared++;
            if (i == 63) begin
                if (M3_SRAM_address !== 18'd79047 || M3_SRAM_write_data !== 16'd16) begin
                    mismatched++;
                    $display("FAIL block0_last: got addr=%0d data=%0d required addr=79047 data=16", M3_SRAM_address, M3_SRAM_write_data);
                end
                compared++;
            end
            if (i == 64) begin
                if (M3_SRAM_address !== 18'd76808) begin
                    mismatched++; $display("FAIL block1_first: got addr=%0d required 76808", M3_SRAM_address);
                end
                compared++;
            end
            seq++;
        end
    endtask

    task automatic test_valid_gaps();
        bit pat [0:3] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int writes = 0;
        for (int i = 0; i < 4; i++) begin
            int ea = exp_addr(seq);
            logic [15:0] cd = 16'(100 + i);
            logic [15:0] ed = exp_data(cd, seq % 64, qsel_m);
            send(pat[i], cd);
            if (pat[i]) begin
                writes++;
                if (M3_SRAM_we_n !== 1'b0 || M3_SRAM_address !== 18'(ea) || M3_SRAM_write_data !== ed) begin
                    mismatched++;
                    $display("FAIL gap_write%0d: got we_n=%b addr=%0d data=%h required we_n=0 addr=%0d data=%h",
                             i, M3_SRAM_we_n, M3_SRAM_address, M3_SRAM_write_data, ea, ed);
                end
                seq++;
            end else if (M3_SRAM_we_n !== 1'b1) begin
                mismatched++; $display("FAIL gap_idle%0d: got we_n=%b required 1", i, M3_SRAM_we_n);
            end
            compared++;
        end
    endtask

    task automatic test_saturation();
        logic [15:0] cin  [0:2] = '{16'h7000, 16'h9000, 16'hFFFF};
        logic [15:0] cout [0:2] = '{16'h7FFF, 16'h8000, 16'hFFF8};
        for (int i = 0; i < 3; i++) begin
            restart(1'b0);
            send(1'b1, cin[i]);
            if (M3_SRAM_we_n !== 1'b0 || M3_SRAM_write_data !== cout[i] || M3_SRAM_address !== 18'd76800) begin
                mismatched++;
                $display("FAIL saturate_%h: got we_n=%b addr=%0d data=%h required we_n=0 addr=76800 data=%h",
                         cin[i], M3_SRAM_we_n, M3_SRAM_address, M3_SRAM_write_data, cout[i]);
            end
            compared++;
        end
    endtask

    task automatic test_random();
        restart(1'($urandom_range(0, 1)));
        for (int i = 0; i < 220; i++) begin
            bit v = ($urandom_range(0, 3) != 0);
            logic [15:0] cd = 16'($urandom);
            int ea = exp_addr(seq);
            logic [15:0] ed = exp_data(cd, seq % 64, qsel_m);
            bit edone = (seq % 64 == 63);
            if (i == 50) begin
                // A start pulse mid-run must neither restart nor change the matrix.
                @(negedge clk);
                m3_start = 1'b1; q_sel = ~qsel_m;
                @(negedge clk);
                m3_start = 1'b0;
            end
            send(v, cd);
            if (v) begin
                if (M3_SRAM_we_n !== 1'b0 || M3_SRAM_address !== 18'(ea) || M3_SRAM_write_data !== ed || block_done !== edone) begin
                    mismatched++;
                    $display("FAIL random%0d: got we_n=%b addr=%0d data=%h done=%b required we_n=0 addr=%0d data=%h done=%b",
                             i, M3_SRAM_we_n, M3_SRAM_address, M3_SRAM_write_data, block_done, ea, ed, edone);
                end
                seq++;
            end else if (M3_SRAM_we_n !== 1'b1 || block_done !== 1'b0) begin
                mismatched++;
                $display("FAIL random_idle%0d: got we_n=%b done=%b required 1/0", i, M3_SRAM_we_n, block_done);
            end
            compared++;
        end
    endtask

    task automatic test_transitions();
        int jblk [0:3]  = '{39, 1199, 1799, 2399};
        int jidx [0:3]  = '{63, 63, 63, 62};
        int want [0:3]  = '{79360, 153600, 192000, 230399};
        restart(1'b1);
        for (int j = 0; j < 4; j++) begin
            jump(jblk[j], jidx[j]);
            for (int k = 0; k < 2; k++) begin
                int ea = exp_addr(seq);
                logic [15:0] cd = 16'($urandom);
                logic [15:0] ed = exp_data(cd, seq % 64, qsel_m);
                bit edone = (seq % 64 == 63);
                send(1'b1, cd);
                if (M3_SRAM_we_n !== 1'b0 || M3_SRAM_address !== 18'(ea) || M3_SRAM_write_data !== ed || block_done !== edone) begin
                    mismatched++;
                    $display("FAIL transition%0d_%0d: got we_n=%b addr=%0d data=%h done=%b required we_n=0 addr=%0d data=%h done=%b",
                             j, k, M3_SRAM_we_n, M3_SRAM_address, M3_SRAM_write_data, block_done, ea, ed, edone);
                end
                compared++;
                seq++;
            end
            if (M3_SRAM_address !== 18'(want[j])) begin
                mismatched++; $display("FAIL boundary%0d_addr: got %0d required %0d", j, M3_SRAM_address, want[j]);
            end
            compared++;
        end
        if (coef_ready !== 1'b0 || m3_finish !== 1'b0) begin
            mismatched++; $display("FAIL flush_state: got ready=%b finish=%b required 0/0", coef_ready, m3_finish);
        end
        compared++;
        @(posedge clk);
        #1;
        if (m3_finish !== 1'b1 || M3_SRAM_we_n !== 1'b1 || coef_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL finish_pulse: got finish=%b we_n=%b ready=%b required 1/1/0", m3_finish, M3_SRAM_we_n, coef_ready);
        end
        compared++;
        @(posedge clk);
        #1;
        if (m3_finish !== 1'b0 || coef_ready !== 1'b0) begin
            mismatched++; $display("FAIL finish_end: got finish=%b ready=%b required 0/0", m3_finish, coef_ready);
        end
        compared++;
        send(1'b1, 16'h1234);
        if (M3_SRAM_we_n !== 1'b1 || m3_finish !== 1'b0) begin
            mismatched++; $display("FAIL idle_valid_ignored: got we_n=%b finish=%b required 1/0", M3_SRAM_we_n, m3_finish);
        end
        compared++;
    endtask

    task automatic test_async_reset();
        restart(1'b0);
        send(1'b1, 16'd7);
        send(1'b1, 16'd7);
        @(negedge clk);
        coef_valid = 1'b1; coef_data = 16'd9;
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        if (M3_SRAM_we_n !== 1'b1 || coef_ready !== 1'b0 || M3_SRAM_address !== 18'd0 ||
            M3_SRAM_write_data !== 16'd0 || block_done !== 1'b0) begin
            mismatched++;
            $display("FAIL async_reset: got we_n=%b ready=%b addr=%0d data=%h done=%b required 1/0/0/0000/0",
                     M3_SRAM_we_n, coef_ready, M3_SRAM_address, M3_SRAM_write_data, block_done);
        end
        compared++;
        coef_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (m3_finish !== 1'b0 || M3_SRAM_we_n !== 1'b1) begin
                mismatched++; $display("FAIL reset_hold%0d: got finish=%b we_n=%b required 0/1", i, m3_finish, M3_SRAM_we_n);
            end
            compared++;
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        m3_start = 1'b1; q_sel = 1'b0;
        @(negedge clk);
        m3_start = 1'b0;
        send(1'b1, 16'd2);
        if (M3_SRAM_we_n !== 1'b0 || M3_SRAM_address !== 18'd76800 || M3_SRAM_write_data !== 16'd16) begin
            mismatched++;
            $display("FAIL restart_addr: got we_n=%b addr=%0d data=%0d required we_n=0 addr=76800 data=16",
                     M3_SRAM_we_n, M3_SRAM_address, M3_SRAM_write_data);
        end
        compared++;
    endtask

    initial begin
        build_zigzag();
        test_reset();
        test_first_coefs();
        test_full_block();
        test_valid_gaps();
        test_saturation();
        test_random();
        test_transitions();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
